// File: rtl/ifetch_queue.sv
// Instruction fetch front end: fetches aligned 32-bit words, splits them into 16-bit parcels,
// and buffers them with their PCs. Redirects, mid-word entry and bus faults are handled here.
module ifetch_queue #(
    parameter int              RV       = 32,
    parameter int              QDEPTH   = 4,
    parameter logic [RV-1:0]   RESET_PC = '0
) (
    input  logic          clk,
    input  logic          reset,
    output logic          ireq,
    output logic [RV-1:0] iaddr,
    input  logic          iack,
    input  logic [31:0]   irdata,
    input  logic          ierr,
    input  logic          jump,
    input  logic [RV-1:0] jump_pc,
    input  logic          stall,
    output logic [15:0]   ins,
    output logic          idone,
    output logic [RV-1:0] ipc,
    output logic          ifault
);
    localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(QDEPTH);
    localparam logic [RV-1:0] PC_MASK = {{(RV-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DISCARD, S_HALT} state_t;

    state_t        r_state;
    logic          r_ireq;
    logic [RV-1:0] r_iaddr;
    logic [RV-1:0] r_fetch_pc;

    logic [15:0]   r_q_ins [QDEPTH];
    logic [RV-1:0] r_q_pc  [QDEPTH];
    logic          r_q_flt [QDEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic          w_take;
    logic [1:0]    w_push_n;
    logic [15:0]   w_d0;
    logic [RV-1:0] w_pc0;
    logic          w_f0;
    logic [RV-1:0] w_pc_hi;
    logic [CW-1:0] w_free;
    logic          w_pop;

    assign w_pc_hi = r_iaddr + RV'(2);
    assign w_free  = DEPTH_C - r_count;
    // A response coinciding with a redirect belongs to the old stream and is dropped.
    assign w_take  = (r_state == S_REQ) & iack & ~jump;

    always_comb begin
        w_push_n = 2'd0;
        w_d0     = irdata[15:0];
        w_pc0    = r_iaddr;
        w_f0     = 1'b0;
        if (w_take) begin
            if (ierr) begin
                w_push_n = 2'd1;
                w_d0     = 16'h0000;
                w_pc0    = r_fetch_pc;
                w_f0     = 1'b1;
            end else if (r_fetch_pc[1]) begin
                w_push_n = 2'd1;
                w_d0     = irdata[31:16];
                w_pc0    = w_pc_hi;
            end else begin
                w_push_n = 2'd2;
            end
        end
    end

    assign w_pop  = (r_count != '0) & ~stall & ~jump;
    assign idone  = w_pop;
    assign ins    = r_q_ins[r_head];
    assign ipc    = r_q_pc[r_head];
    assign ifault = r_q_flt[r_head];
    assign ireq   = r_ireq;
    assign iaddr  = r_iaddr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                r_q_ins[i] <= '0;
                r_q_pc[i]  <= RESET_PC & PC_MASK;
                r_q_flt[i] <= 1'b0;
            end
        end else if (jump) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_n != 2'd0) begin
                r_q_ins[r_tail] <= w_d0;
                r_q_pc[r_tail]  <= w_pc0;
                r_q_flt[r_tail] <= w_f0;
            end
            if (w_push_n == 2'd2) begin
                r_q_ins[r_tail + AW'(1)] <= irdata[31:16];
                r_q_pc[r_tail + AW'(1)]  <= w_pc_hi;
                r_q_flt[r_tail + AW'(1)] <= 1'b0;
            end
            r_tail  <= r_tail + AW'(w_push_n);
            if (w_pop)
                r_head <= r_head + AW'(1);
            r_count <= r_count + CW'(w_push_n) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_ireq     <= 1'b0;
            r_iaddr    <= {RESET_PC[RV-1:2], 2'b00};
            r_fetch_pc <= RESET_PC & PC_MASK;
        end else begin
            if (jump)
                r_fetch_pc <= jump_pc & PC_MASK;
            case (r_state)
                S_IDLE: begin
                    // Two free slots guarantee any response fits, even with pops stalled.
                    if (!jump && w_free >= CW'(2)) begin
                        r_state <= S_REQ;
                        r_ireq  <= 1'b1;
                        r_iaddr <= {r_fetch_pc[RV-1:2], 2'b00};
                    end
                end
                S_REQ: begin
                    if (jump) begin
                        if (iack) begin
                            r_state <= S_IDLE;
                            r_ireq  <= 1'b0;
                        end else begin
                            r_state <= S_DISCARD;
                        end
                    end else if (iack) begin
                        r_ireq <= 1'b0;
                        if (ierr) begin
                            r_state <= S_HALT;
                        end else begin
                            r_state    <= S_IDLE;
                            r_fetch_pc <= r_iaddr + RV'(4);
                        end
                    end
                end
                S_DISCARD: begin
                    if (iack) begin
                        r_state <= S_IDLE;
                        r_ireq  <= 1'b0;
                    end
                end
                S_HALT: begin
                    if (jump)
                        r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ireq  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: reset, sequential fetch, mid-word entry, redirect discard,
// back-pressure and fetch faults, each checked against hand-computed parcel streams.
module tb_ifetch_queue;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ireq;
    logic [31:0] iaddr;
    logic        iack = 1'b0;
    logic [31:0] irdata = '0;
    logic        ierr = 1'b0;
    logic        jump = 1'b0;
    logic [31:0] jump_pc = '0;
    logic        stall = 1'b0;
    logic [15:0] ins;
    logic        idone;
    logic [31:0] ipc;
    logic        ifault;

    int checks = 0;
    int errors = 0;
    int cyc_cnt = 0;

    logic [15:0] log_ins[$];
    logic [31:0] log_pc[$];
    logic        log_flt[$];
    int          log_cyc[$];

    ifetch_queue #(.RV(32), .QDEPTH(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset), .ireq(ireq), .iaddr(iaddr), .iack(iack),
        .irdata(irdata), .ierr(ierr), .jump(jump), .jump_pc(jump_pc), .stall(stall),
        .ins(ins), .idone(idone), .ipc(ipc), .ifault(ifault)
    );

    always #5 clk = ~clk;

    // Inputs change at posedge+2; delivered parcels are logged at posedge+3.
    initial forever begin
        @(posedge clk);
        #3;
        cyc_cnt++;
        if (reset && idone) begin
            log_ins.push_back(ins);
            log_pc.push_back(ipc);
            log_flt.push_back(ifault);
            log_cyc.push_back(cyc_cnt);
        end
    end

    task automatic clear_log();
        log_ins.delete(); log_pc.delete(); log_flt.delete(); log_cyc.delete();
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        next_cyc();
        reset = 1'b0; iack = 1'b0; ierr = 1'b0; jump = 1'b0; stall = 1'b0; irdata = '0;
        next_cyc();
        reset = 1'b1;
        clear_log();
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (ireq) begin
                ok = 1'b1;
                break;
            end
            next_cyc();
        end
    endtask

    task automatic ack(input logic [31:0] d, input logic e);
        iack = 1'b1; irdata = d; ierr = e;
        next_cyc();
        iack = 1'b0; ierr = 1'b0;
    endtask

    task automatic test_reset();
        bit ok;
        do_reset();
        wait_req(ok);
        ack(32'h5678_1234, 1'b0);
        wait_req(ok);
        checks++;
        if (!ok || iaddr !== 32'h4) begin
            errors++; $display("FAIL reset_pre_req: ok=%0d iaddr=%h want 00000004", ok, iaddr);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (ireq !== 1'b0) begin errors++; $display("FAIL reset_ireq: got %b want 0", ireq); end
        checks++;
        if (iaddr !== 32'h0) begin errors++; $display("FAIL reset_iaddr: got %h want 0", iaddr); end
        checks++;
        if (idone !== 1'b0) begin errors++; $display("FAIL reset_idone: got %b want 0", idone); end
        checks++;
        if (ins !== 16'h0) begin errors++; $display("FAIL reset_ins: got %h want 0000", ins); end
        checks++;
        if (ipc !== 32'h0 || ifault !== 1'b0) begin
            errors++; $display("FAIL reset_ipc_ifault: got %h/%b want 0/0", ipc, ifault);
        end
        next_cyc();
        reset = 1'b1;
        clear_log();
        #1;
        checks++;
        if (ireq !== 1'b0) begin errors++; $display("FAIL reset_release_ireq: got %b want 0", ireq); end
        next_cyc();
        checks++;
        if (ireq !== 1'b1 || iaddr !== 32'h0) begin
            errors++; $display("FAIL reset_first_req: got ireq=%b iaddr=%h want 1/0", ireq, iaddr);
        end
    endtask

    task automatic test_sequential();
        bit ok1, ok2;
        logic [15:0] exp_ins [4] = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};
        logic [31:0] exp_pc [4]  = '{32'h0, 32'h2, 32'h4, 32'h6};
        do_reset();
        wait_req(ok1);
        checks++;
        if (!ok1 || iaddr !== 32'h0) begin errors++; $display("FAIL seq_addr0: ok=%0d iaddr=%h want 0", ok1, iaddr); end
        ack(32'hBBBB_AAAA, 1'b0);
        wait_req(ok2);
        checks++;
        if (!ok2 || iaddr !== 32'h4) begin errors++; $display("FAIL seq_addr4: ok=%0d iaddr=%h want 4", ok2, iaddr); end
        ack(32'hDDDD_CCCC, 1'b0);
        repeat (4) next_cyc();
        checks++;
        if (log_ins.size() != 4) begin
            errors++; $display("FAIL seq_count: got %0d parcels want 4", log_ins.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (log_ins[i] !== exp_ins[i] || log_pc[i] !== exp_pc[i] || log_flt[i] !== 1'b0) begin
                    errors++;
                    $display("FAIL seq_parcel%0d: got %h@%h f=%b want %h@%h f=0", i, log_ins[i], log_pc[i], log_flt[i], exp_ins[i], exp_pc[i]);
                end
            end
            checks++;
            if (log_cyc[3] - log_cyc[0] != 3) begin
                errors++; $display("FAIL seq_bubbles: got span %0d want 3", log_cyc[3] - log_cyc[0]);
            end
        end
    endtask

    task automatic test_mid_word();
        bit ok;
        do_reset();
        jump = 1'b1; jump_pc = 32'h103;
        next_cyc();
        jump = 1'b0;
        wait_req(ok);
        checks++;
        if (!ok || iaddr !== 32'h100) begin errors++; $display("FAIL mid_addr: ok=%0d iaddr=%h want 00000100", ok, iaddr); end
        ack(32'h2222_1111, 1'b0);
        wait_req(ok);
        checks++;
        if (!ok || iaddr !== 32'h104) begin errors++; $display("FAIL mid_next_addr: ok=%0d iaddr=%h want 00000104", ok, iaddr); end
        checks++;
        if (log_ins.size() != 1) begin
            errors++; $display("FAIL mid_count: got %0d parcels want 1", log_ins.size());
        end else if (log_ins[0] !== 16'h2222 || log_pc[0] !== 32'h102) begin
            errors++; $display("FAIL mid_parcel: got %h@%h want 2222@00000102", log_ins[0], log_pc[0]);
        end
    endtask

    task automatic test_discard();
        bit ok;
        int held_bad = 0;
        do_reset();
        wait_req(ok);
        jump = 1'b1; jump_pc = 32'h200;
        next_cyc();
        jump = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (ireq !== 1'b1 || iaddr !== 32'h0) held_bad++;
            next_cyc();
        end
        checks++;
        if (held_bad != 0) begin errors++; $display("FAIL discard_hold: got %0d bad cycles want 0", held_bad); end
        ack(32'hDEAD_BEEF, 1'b0);
        wait_req(ok);
        checks++;
        if (!ok || iaddr !== 32'h200) begin errors++; $display("FAIL discard_target: ok=%0d iaddr=%h want 00000200", ok, iaddr); end
        ack(32'h4444_3333, 1'b0);
        repeat (3) next_cyc();
        checks++;
        if (log_ins.size() != 2) begin
            errors++; $display("FAIL discard_count: got %0d parcels want 2", log_ins.size());
        end else if (log_ins[0] !== 16'h3333 || log_pc[0] !== 32'h200 ||
                     log_ins[1] !== 16'h4444 || log_pc[1] !== 32'h202) begin
            errors++;
            $display("FAIL discard_stream: got %h@%h %h@%h want 3333@200 4444@202", log_ins[0], log_pc[0], log_ins[1], log_pc[1]);
        end
    endtask

    task automatic test_stall();
        int nf = 0;
        logic [15:0] exp_ins [4] = '{16'hA000, 16'hA002, 16'hA004, 16'hA006};
        do_reset();
        stall = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (ireq && !iack) begin
                iack = 1'b1;
                irdata = {16'hA000 | 16'(iaddr[11:0] + 12'd2), 16'hA000 | 16'(iaddr[11:0])};
                nf++;
            end else begin
                iack = 1'b0;
            end
            next_cyc();
        end
        iack = 1'b0;
        checks++;
        if (nf != 2) begin errors++; $display("FAIL stall_fetches: got %0d want 2", nf); end
        checks++;
        if (ireq !== 1'b0 || log_ins.size() != 0) begin
            errors++; $display("FAIL stall_idle: got ireq=%b parcels=%0d want 0/0", ireq, log_ins.size());
        end
        stall = 1'b0;
        repeat (6) next_cyc();
        checks++;
        if (log_ins.size() != 4) begin
            errors++; $display("FAIL stall_count: got %0d parcels want 4", log_ins.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (log_ins[i] !== exp_ins[i] || log_pc[i] !== 32'(2 * i)) begin
                    errors++; $display("FAIL stall_parcel%0d: got %h@%h want %h@%h", i, log_ins[i], log_pc[i], exp_ins[i], 32'(2 * i));
                end
            end
        end
    endtask

    task automatic test_fault();
        bit ok;
        int req_bad = 0;
        do_reset();
        jump = 1'b1; jump_pc = 32'h20;
        next_cyc();
        jump = 1'b0;
        wait_req(ok);
        checks++;
        if (!ok || iaddr !== 32'h20) begin errors++; $display("FAIL fault_addr: ok=%0d iaddr=%h want 00000020", ok, iaddr); end
        ack(32'hFFFF_FFFF, 1'b1);
        #1;
        checks++;
        if (idone !== 1'b1 || ins !== 16'h0 || ifault !== 1'b1 || ipc !== 32'h20) begin
            errors++;
            $display("FAIL fault_entry: got idone=%b ins=%h ifault=%b ipc=%h want 1/0000/1/00000020", idone, ins, ifault, ipc);
        end
        for (int i = 0; i < 6; i++) begin
            next_cyc();
            if (ireq !== 1'b0) req_bad++;
        end
        checks++;
        if (req_bad != 0) begin errors++; $display("FAIL fault_halt: got %0d ireq cycles want 0", req_bad); end
        checks++;
        if (log_ins.size() != 1) begin errors++; $display("FAIL fault_count: got %0d parcels want 1", log_ins.size()); end
        jump = 1'b1; jump_pc = 32'h40;
        next_cyc();
        jump = 1'b0;
        wait_req(ok);
        checks++;
        if (!ok || iaddr !== 32'h40) begin errors++; $display("FAIL fault_resume: ok=%0d iaddr=%h want 00000040", ok, iaddr); end
        ack(32'h6666_5555, 1'b0);
        #1;
        checks++;
        if (idone !== 1'b1 || ins !== 16'h5555 || ipc !== 32'h40 || ifault !== 1'b0) begin
            errors++; $display("FAIL fault_resume_data: got %b %h@%h f=%b want 1 5555@00000040 f=0", idone, ins, ipc, ifault);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_mid_word();
        test_discard();
        test_stall();
        test_fault();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
